// File: rtl/mixer_pkg.sv
// Shared types and defaults for the codec mixer: FSM states, default
// parameter values and the width of the volume (attenuation) control.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUM     = 2'd2,
        SAT     = 2'd3
    } state_t;

    localparam int DEF_NUM_VOICES   = 4;
    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_TIMEOUT      = 255;
    localparam int VOL_WIDTH        = 3;

endpackage

// File: rtl/sat_shift.sv
// Arithmetic right shift followed by saturation from IN_W to OUT_W bits.
// IN_W must be at least OUT_W.
module sat_shift
    import mixer_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]      din,
    input  logic        [VOL_WIDTH-1:0] shift,
    output logic signed [OUT_W-1:0]     dout
);

    localparam logic signed [IN_W-1:0] MAX_V =
        {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V =
        {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] shifted;

    // Attenuate, then clamp into the output range
    always_comb begin
        shifted = din >>> shift;
        if (shifted > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
        end else if (shifted < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
        end else begin
            dout = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/codec_mixer.sv
// Voice mixer feeding a codec: on each frame strobe it presents the pending
// mixed sample, requests fresh samples from the voices, collects them (with
// a timeout), sums them serially, attenuates/saturates and buffers the result.
module codec_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_VOICES   = DEF_NUM_VOICES,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               new_frame,
    input  logic                               play,
    input  logic [NUM_VOICES-1:0]              voice_enable,
    input  logic [NUM_VOICES-1:0]              voice_valid,
    input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_sample,
    input  logic [VOL_WIDTH-1:0]               volume,
    output logic                               generate_next_sample,
    output logic [SAMPLE_WIDTH-1:0]            sample_out,
    output logic                               new_sample_ready,
    output logic                               underrun,
    output logic                               late
);

    localparam int ACC_W = SAMPLE_WIDTH + $clog2(NUM_VOICES);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t                          state_reg;
    logic                            new_frame_d_reg;
    logic                            buf_full_reg;
    logic [SAMPLE_WIDTH-1:0]         buf_data_reg;
    logic signed [ACC_W-1:0]         acc_reg;
    logic [IDX_W-1:0]                sum_idx_reg;
    logic [TMR_W-1:0]                timer_reg;
    logic [NUM_VOICES-1:0]           captured_reg;
    logic signed [SAMPLE_WIDTH-1:0]  hold_reg [NUM_VOICES];

    logic                            frame_edge;
    logic                            all_done;
    logic signed [ACC_W-1:0]         addend;
    logic signed [SAMPLE_WIDTH-1:0]  sat_value;
    logic [SAMPLE_WIDTH-1:0]         mixed;

    assign frame_edge = new_frame & ~new_frame_d_reg;
    assign all_done   = ((captured_reg | (voice_valid & voice_enable)) & voice_enable)
                        == voice_enable;
    assign mixed      = play ? sat_value : '0;

    // Serial summation picks one held voice per SUM cycle
    always_comb begin
        addend = '0;
        if (captured_reg[sum_idx_reg] && voice_enable[sum_idx_reg]) begin
            addend = ACC_W'(hold_reg[sum_idx_reg]);
        end
    end

    sat_shift #(
        .IN_W  (ACC_W),
        .OUT_W (SAMPLE_WIDTH)
    ) u_sat_shift (
        .din   (acc_reg),
        .shift (volume),
        .dout  (sat_value)
    );

    // Latch each enabled voice once per collection window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            captured_reg <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                hold_reg[i] <= '0;
            end
        end else if (state_reg == IDLE && frame_edge) begin
            captured_reg <= '0;
        end else if (state_reg == COLLECT) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (voice_valid[i] && voice_enable[i] && !captured_reg[i]) begin
                    captured_reg[i] <= 1'b1;
                    hold_reg[i]     <= voice_sample[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                end
            end
        end
    end

    // Frame handling: present buffer (or bypass the SAT result), track fullness
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_frame_d_reg <= 1'b0;
            sample_out      <= '0;
            buf_full_reg    <= 1'b0;
            buf_data_reg    <= '0;
            underrun        <= 1'b0;
        end else begin
            new_frame_d_reg <= new_frame;
            underrun        <= 1'b0;
            if (frame_edge && state_reg == SAT) begin
                sample_out   <= mixed;
                buf_full_reg <= 1'b0;
            end else if (state_reg == SAT) begin
                buf_data_reg <= mixed;
                buf_full_reg <= 1'b1;
            end else if (frame_edge) begin
                if (buf_full_reg) begin
                    sample_out   <= buf_data_reg;
                    buf_full_reg <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    // Mixing FSM: request, collect with timeout, serial sum, saturate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg            <= IDLE;
            acc_reg              <= '0;
            sum_idx_reg          <= '0;
            timer_reg            <= '0;
            generate_next_sample <= 1'b0;
            new_sample_ready     <= 1'b0;
            late                 <= 1'b0;
        end else begin
            generate_next_sample <= 1'b0;
            new_sample_ready     <= 1'b0;
            late                 <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame_edge) begin
                        state_reg            <= COLLECT;
                        generate_next_sample <= 1'b1;
                        timer_reg            <= '0;
                    end
                end
                COLLECT: begin
                    if (all_done || timer_reg == TMR_W'(TIMEOUT - 1)) begin
                        state_reg   <= SUM;
                        acc_reg     <= '0;
                        sum_idx_reg <= '0;
                        late        <= ~all_done;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                SUM: begin
                    acc_reg     <= acc_reg + addend;
                    sum_idx_reg <= sum_idx_reg + 1'b1;
                    if (sum_idx_reg == IDX_W'(NUM_VOICES - 1)) begin
                        state_reg <= SAT;
                    end
                end
                SAT: begin
                    new_sample_ready <= 1'b1;
                    state_reg        <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
